// File: rtl/mips_pkg.sv
// Shared MIPS decode/execute definitions: ALU opcodes for the HI/LO unit
// and the mult/div sequencer state encoding.
package mips_pkg;

   localparam logic [3:0] ALU_DIV   = 4'b1100;
   localparam logic [3:0] ALU_DIVU  = 4'b1101;
   localparam logic [3:0] ALU_MULT  = 4'b1110;
   localparam logic [3:0] ALU_MULTU = 4'b1111;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      DIV,
      FIXUP
   } md_state_t;

endpackage

// File: rtl/mult_div_abs_neg.sv
// Conditional two's-complement negate, used for operand magnitudes and
// for restoring result signs.
module abs_neg #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] val,
   input  logic             neg,
   output logic [WIDTH-1:0] res
);

   assign res = neg ? ('0 - val) : val;

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO.
// Optional single-cycle multiplier: define MULT_DIV_FAST_MULT_EN.
module mult_div_unit
   import mips_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       alu_op,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             hi_wr_en,
   input  logic             lo_wr_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   md_state_t          state;
   logic [CW-1:0]      count;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   opnd;
   logic               sign_q;
   logic               sign_r;
   logic               div_zero;
   logic               mul_op_q;

   logic               valid_op;
   logic               signed_op;
   logic               mul_op;
   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH-1:0]   abs_b;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] div_next;
   logic [2*WIDTH-1:0] fix_prod;
   logic [WIDTH-1:0]   fix_rem;

   assign valid_op  = (alu_op == ALU_DIV) || (alu_op == ALU_DIVU) ||
                      (alu_op == ALU_MULT) || (alu_op == ALU_MULTU);
   assign signed_op = (alu_op == ALU_DIV) || (alu_op == ALU_MULT);
   assign mul_op    = (alu_op == ALU_MULT) || (alu_op == ALU_MULTU);
   assign busy      = (state != IDLE);

   abs_neg #(.WIDTH(WIDTH)) u_abs_a (
      .val (op_a),
      .neg (signed_op && op_a[WIDTH-1]),
      .res (abs_a)
   );

   abs_neg #(.WIDTH(WIDTH)) u_abs_b (
      .val (op_b),
      .neg (signed_op && op_b[WIDTH-1]),
      .res (abs_b)
   );

   // Low half of the 2W negate equals the W-bit negate of the quotient.
   abs_neg #(.WIDTH(2*WIDTH)) u_neg_prod (
      .val (acc),
      .neg (sign_q),
      .res (fix_prod)
   );

   abs_neg #(.WIDTH(WIDTH)) u_neg_rem (
      .val (acc[2*WIDTH-1:WIDTH]),
      .neg (sign_r),
      .res (fix_rem)
   );

   // Restoring step: acc = {remainder, dividend bits / quotient bits}.
   assign div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
   assign div_next = div_diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

`ifdef MULT_DIV_FAST_MULT_EN
   logic [2*WIDTH-1:0] prod_fast;
   assign prod_fast = {{WIDTH{1'b0}}, opnd} * {{WIDTH{1'b0}}, acc[WIDTH-1:0]};
`else
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : '0)};
   assign mul_next = {mul_sum, acc[WIDTH-1:1]};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         count    <= '0;
         acc      <= '0;
         opnd     <= '0;
         sign_q   <= 1'b0;
         sign_r   <= 1'b0;
         div_zero <= 1'b0;
         mul_op_q <= 1'b0;
         done     <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (hi_wr_en) hi <= wr_data;
               if (lo_wr_en) lo <= wr_data;
               if (start && valid_op) begin
                  count    <= CW'(WIDTH-1);
                  mul_op_q <= mul_op;
                  div_zero <= !mul_op && (op_b == '0);
                  sign_q   <= signed_op && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                  sign_r   <= !mul_op && signed_op && op_a[WIDTH-1];
                  if (mul_op) begin
                     opnd  <= abs_a;
                     acc   <= {{WIDTH{1'b0}}, abs_b};
                     state <= MUL;
                  end else begin
                     opnd  <= abs_b;
                     acc   <= {{WIDTH{1'b0}}, abs_a};
                     state <= DIV;
                  end
               end
            end
            MUL: begin
`ifdef MULT_DIV_FAST_MULT_EN
               acc   <= prod_fast;
               state <= FIXUP;
`else
               acc   <= mul_next;
               count <= count - CW'(1);
               if (count == '0) state <= FIXUP;
`endif
            end
            DIV: begin
               acc   <= div_next;
               count <= count - CW'(1);
               if (count == '0) state <= FIXUP;
            end
            FIXUP: begin
               // Divide by zero leaves |a| as remainder, so HI restores raw op_a.
               if (mul_op_q) begin
                  hi <= fix_prod[2*WIDTH-1:WIDTH];
                  lo <= fix_prod[WIDTH-1:0];
               end else begin
                  hi <= fix_rem;
                  lo <= div_zero ? '1 : fix_prod[WIDTH-1:0];
               end
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
